// File: rtl/mem_scan_pkg.sv
// Shared constants and the counter-width helper for the scanned dual-port memory.
// Imported by mem_scan_dp and dwell_timer.
package mem_scan_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 3;
    localparam int DWELL_DEF  = 50_000_000;

    // Width of the dwell counter, never below one bit so DWELL=1 still synthesizes.
    function automatic int cnt_width(input int dwell);
        int w;
        w = $clog2(dwell);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Free-running dwell counter: asserts tick for one cycle every DWELL enabled cycles.
// Count holds whenever en is low; synchronous active-high reset clears it.
module dwell_timer
    import mem_scan_pkg::*;
#(
    parameter int DWELL = DWELL_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int          CW   = cnt_width(DWELL);
    localparam logic [31:0] LAST = 32'(DWELL - 1);

    logic [CW-1:0] cnt;
    logic          at_last;

    // Compare at 32 bits so the terminal value is never truncated to CW bits.
    assign at_last = (32'(cnt) == LAST);
    assign tick    = en & at_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (en) begin
            if (at_last) cnt <= '0;
            else         cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mem_scan_dp.sv
// Dual-port memory with registered read and an auto-incrementing scan read address.
// Define MEM_SCAN_WR_BYPASS_EN for write-first forwarding on same-address read/write.
module mem_scan_dp
    import mem_scan_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DWELL  = DWELL_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              scan_mode,
    input  logic              scan_pause,
    input  logic [ADDR_W-1:0] man_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              step
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] scan_addr;
    logic [ADDR_W-1:0] sel_addr;
    logic              scan_en;
    logic              tick;

    assign scan_en  = scan_mode & ~scan_pause;
    assign sel_addr = scan_mode ? scan_addr : man_addr;

    dwell_timer #(.DWELL(DWELL)) u_timer (
        .clk   (clk),
        .reset (reset),
        .en    (scan_en),
        .tick  (tick)
    );

    // step is registered so it lines up with the cycle the new scan address is live.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_addr <= '0;
            step      <= 1'b0;
        end else begin
            step <= tick;
            if (tick) scan_addr <= scan_addr + ADDR_W'(1);
        end
    end

    // Storage sits outside the reset domain: writes land even while reset is high.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr <= '0;
            rd_data <= '0;
        end else begin
            rd_addr <= sel_addr;
`ifdef MEM_SCAN_WR_BYPASS_EN
            if (wr_en && (wr_addr == sel_addr)) rd_data <= wr_data;
            else                                rd_data <= mem[sel_addr];
`else
            rd_data <= mem[sel_addr];
`endif
        end
    end

endmodule

// File: doc/mem_scan_dp.md
Name: mem_scan_dp

Overview:
- Parametrised dual-port memory: synchronous write port plus a read port fed either by a manual address or by an internal auto-incrementing scan address.
- The scan address advances once every DWELL cycles, so board-level tops can cycle through all memory contents on the HEX displays.
- Generalises the fixed 32x3 single-port RAM: width and depth are parametrised, read and write are separated, and an address scanner is added.

Parameters:
- ADDR_W, 5, address width; depth = 2**ADDR_W words.
- DATA_W, 3, word width in bits.
- DWELL, 50_000_000, clk cycles per scan step (1 s at 50 MHz); legal range >= 1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- wr_en  in  1  write strobe; 1 = write wr_data to wr_addr this edge.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- scan_mode  in  1  1 = read address from scanner; 0 = read address from man_addr.
- scan_pause  in  1  1 = freeze scanner (address and dwell count hold).
- man_addr  in  ADDR_W  manual read address.
- rd_addr  out  ADDR_W  address whose data is currently on rd_data.
- rd_data  out  DATA_W  registered read data.
- step  out  1  one-cycle pulse when the scan address advances.

Behaviour:
- Reset values: scan address 0, dwell count 0, rd_addr 0, rd_data 0, step 0.
- Memory contents are not cleared by reset.
- Write: on the clk edge with wr_en=1, mem[wr_addr] <= wr_data. No other side effects.
- Read select: sel_addr = scan_mode ? scan_addr : man_addr.
- Read latency is 1 cycle. rd_addr <= sel_addr and rd_data <= mem[sel_addr] on every edge; the pair is always coherent.
- Read-during-write to the same address returns the OLD data (read-first). The new data is visible one cycle later.
- Scanner runs only when scan_mode=1 and scan_pause=0. In all other cases, count and scan address hold.
- While running, the dwell count increments each cycle. When it reaches DWELL-1:
  - count -> 0
  - scan_addr -> scan_addr+1, wrapping 2**ADDR_W-1 -> 0
  - step=1 for that cycle
- DWELL=1 advances every cycle, with step held high continuously.
- Switching scan_mode 1->0 holds the scanner state. Returning to 1 resumes from the held address and count; there is no restart.
- Reset asserted mid-dwell: the count and address clear at that edge, and the next step occurs DWELL cycles after reset deasserts.
- Reset with wr_en=1 in the same cycle: the write still occurs, since the memory is not part of the reset domain.
- Counter width: $clog2(DWELL) bits, minimum 1. The compare uses DWELL-1 at full width, with no truncation.

Optional Feature:
- Macro: MEM_SCAN_WR_BYPASS_EN.
- Defined: write-first forwarding. If wr_en=1 and wr_addr==sel_addr, rd_data <= wr_data that edge.
- Undefined: read-first behaviour as specified above.
- The port list is identical in both builds.

Decomposition:
- Package mem_scan_pkg holds:
  - default constants ADDR_W_DEF=5, DATA_W_DEF=3, DWELL_DEF=50_000_000
  - the function for counter width.
- Sub-module dwell_timer (params DWELL; ports clk, reset, en, tick) generates the step tick. The top owns the memory array, scan address register and read mux.

Test Plan (DWELL=4, ADDR_W=5, DATA_W=3 unless noted):
- Reset then idle, scan_mode=0, man_addr=0: rd_addr=0, rd_data=0 (after pre-loading mem[0]=0), step=0. Write mem[7]=5, then man_addr=7: rd_data=5 one cycle later.
- Preload mem[i]=i%8, scan_mode=1, scan_pause=0:
  - step pulses every 4 cycles
  - rd_addr sequence 0,1,2,…,31,0
  - rd_data tracks rd_addr
  - wrap from 31 to 0 is observed.
- Scanning, scan_pause=1 for 10 cycles at count 2: rd_addr constant and no step. After release, the next step comes 1 cycle later (count 2->3->advance).
- Same-address read-during-write, mem[3]=1, man_addr=3, write 6 to addr 3:
  - that edge rd_data=1
  - next edge rd_data=6
  - with MEM_SCAN_WR_BYPASS_EN, rd_data=6 on the write edge.
- Reset pulsed at scan address 12, count 2: scan address returns to 0 and count to 0. The first step arrives exactly 4 cycles after reset deasserts. Memory contents are unchanged (mem[5] still reads back its value).
- DWELL=1 build: step stays high and rd_addr increments every cycle while scanning.
